// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART constants, parity selection and state codes.
// Define PARITY_ODD for odd parity; even parity otherwise.
package uart_tx_pkg;
    localparam int OVERSAMPLING = 16;
    localparam int NUM_DATA_BITS = 8;
    localparam int NUM_PARITY_BIT = 1;
    localparam int STATES_NUM = 5;
    localparam int STATE_W = $clog2(STATES_NUM);
    localparam logic [STATE_W-1:0] STATE_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] STATE_START_BIT = 3'd1;
    localparam logic [STATE_W-1:0] STATE_DATA_BITS = 3'd2;
    localparam logic [STATE_W-1:0] STATE_PARITY_BIT = 3'd3;
    localparam logic [STATE_W-1:0] STATE_STOP_BIT = 3'd4;
`ifdef PARITY_ODD
    localparam logic PARITY_ODD_SEL = 1'b1;
`else
    localparam logic PARITY_ODD_SEL = 1'b0;
`endif
endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: combinational word-to-parity-bit generator.
module uart_parity_gen
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = NUM_DATA_BITS
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_parity
);
    assign o_parity = PARITY_ODD_SEL ? ~^i_word : ^i_word;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with one-deep holding register for gapless frames.
// Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx #(
    parameter int OVERSAMPLING = uart_tx_pkg::OVERSAMPLING,
    parameter int NUM_DATA_BITS = uart_tx_pkg::NUM_DATA_BITS
) (
    input  logic                     baud,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_DATA_BITS-1:0] data,
    input  logic                     valid,
    output logic                     ready,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);
    import uart_tx_pkg::*;
    localparam int OS_W = $clog2(OVERSAMPLING);
    localparam int DI_W = $clog2(NUM_DATA_BITS);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLING - 1);
    localparam logic [DI_W-1:0] DI_LAST = DI_W'(NUM_DATA_BITS - 1);
    logic [STATE_W-1:0]       r_state;
    logic [OS_W-1:0]          r_os_idx;
    logic [DI_W-1:0]          r_data_idx;
    logic [NUM_DATA_BITS-1:0] r_shift;
    logic [NUM_DATA_BITS-1:0] r_hold;
    logic                     r_hold_full;
    logic                     r_parity;
    logic                     r_done;
    logic                     w_parity;
    logic                     w_bit_end;
    logic                     w_stop_end;
    logic                     w_load;
    uart_parity_gen #(.WIDTH(NUM_DATA_BITS)) u_parity (
        .i_word   (r_hold),
        .o_parity (w_parity)
    );
    assign w_bit_end = r_os_idx == OS_LAST;
`ifdef UART_TX_TWO_STOP_EN
    logic r_second_stop;
    assign w_stop_end = r_state == STATE_STOP_BIT && w_bit_end && r_second_stop;
    always_ff @(posedge baud or posedge reset) begin
        if (reset)
            r_second_stop <= 1'b0;
        else if (!enable || r_state != STATE_STOP_BIT)
            r_second_stop <= 1'b0;
        else if (w_bit_end)
            r_second_stop <= 1'b1;
    end
`else
    assign w_stop_end = r_state == STATE_STOP_BIT && w_bit_end;
`endif
    // The queued word is taken straight from the final stop cycle, so no idle gap appears.
    assign w_load = r_hold_full && (r_state == STATE_IDLE || w_stop_end);
    assign ready = enable && !r_hold_full && !reset;
    assign busy = r_state != STATE_IDLE;
    assign done = r_done;
    assign tx = r_state == STATE_START_BIT  ? 1'b0 :
                r_state == STATE_DATA_BITS  ? r_shift[0] :
                r_state == STATE_PARITY_BIT ? r_parity : 1'b1;
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            r_state     <= STATE_IDLE;
            r_os_idx    <= '0;
            r_data_idx  <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_parity    <= 1'b0;
            r_done      <= 1'b0;
        end else if (!enable) begin
            r_state     <= STATE_IDLE;
            r_os_idx    <= '0;
            r_data_idx  <= '0;
            r_hold_full <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_stop_end;
            if (valid && ready) begin
                r_hold      <= data;
                r_hold_full <= 1'b1;
            end
            if (w_load) begin
                r_shift     <= r_hold;
                r_parity    <= w_parity;
                r_hold_full <= 1'b0;
                r_state     <= STATE_START_BIT;
                r_os_idx    <= '0;
            end else if (r_state != STATE_IDLE) begin
                r_os_idx <= w_bit_end ? '0 : r_os_idx + 1'b1;
                if (w_bit_end) begin
                    if (r_state == STATE_START_BIT) begin
                        r_state    <= STATE_DATA_BITS;
                        r_data_idx <= '0;
                    end else if (r_state == STATE_DATA_BITS) begin
                        r_shift    <= r_shift >> 1;
                        r_data_idx <= r_data_idx + 1'b1;
                        if (r_data_idx == DI_LAST)
                            r_state <= STATE_PARITY_BIT;
                    end else if (r_state == STATE_PARITY_BIT) begin
                        r_state <= STATE_STOP_BIT;
                    end else if (w_stop_end) begin
                        r_state <= STATE_IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmitter counterpart to the UART receiver. Serialises one data word per frame onto the `tx` line.
- Frame format: start bit (low), NUM_DATA_BITS data bits LSB first, one parity bit (even/odd per shared header macro), stop bit (high).
- Clocked by the same oversampled `baud` clock as the receiver. Each bit is held for exactly OVERSAMPLING baud cycles.
- A one-deep holding register lets the host queue the next word while the current frame is on the line, so back-to-back frames need no idle gap.

Parameters:
- OVERSAMPLING, default `OVERSAMPLING (16): baud cycles per bit.
- NUM_DATA_BITS, default `NUM_DATA_BITS (8): data bits per frame.

Ports:
- baud  input  1  oversampled baud clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  transmitter enable; low aborts and idles the block.
- data  input  NUM_DATA_BITS  word to send; sampled when valid && ready.
- valid  input  1  host offers `data` this cycle.
- ready  output  1  holding register empty and enable high; word accepted on posedge when valid && ready.
- tx  output  1  serial line, idles high.
- busy  output  1  a frame is on the line (START through STOP).
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (async, reset=1):
  - tx=1, ready=0 while reset is asserted, busy=0, done=0.
  - state=IDLE; oversample_idx=0; data_idx=0; shift register=0; hold register empty.
  - Once reset is released, ready follows enable.
- enable=0, sampled synchronously with priority over everything except reset:
  - state=IDLE, tx=1, busy=0, done=0, hold register cleared, ready=0.
  - A frame in flight is truncated immediately. A truncated frame never pulses done.
- Acceptance:
  - On posedge with valid && ready: data is stored in the hold register; ready drops the next cycle.
  - data is ignored when ready=0.
- States and transitions (codes from the shared header):
  - IDLE: tx=1, busy=0. If the hold register is full, load the shift register from it, compute parity, empty hold, and go to START. tx goes low on the cycle after the accepting edge, i.e. a latency of 1 baud cycle.
  - START: tx=0 for OVERSAMPLING cycles, then go to DATA_BITS with data_idx=0.
  - DATA_BITS: tx=shift[0]; each bit lasts OVERSAMPLING cycles. On the last cycle of each bit, shift right and increment data_idx. After bit NUM_DATA_BITS-1, go to PARITY_BIT.
  - PARITY_BIT: tx=parity for OVERSAMPLING cycles, then go to STOP_BIT.
  - STOP_BIT: tx=1 for OVERSAMPLING cycles. On the final cycle, assert done for the next cycle. Next state is START (back-to-back) if the hold register is full, else IDLE.
- Parity: computed from the word at load time and frozen for the whole frame.
  - PARITY_EVEN: parity = ^word.
  - PARITY_ODD: parity = ~^word.
- Counters:
  - oversample_idx runs 0..OVERSAMPLING-1 and wraps to 0 at each bit boundary. Width $clog2(OVERSAMPLING).
  - data_idx width $clog2(NUM_DATA_BITS); it does not wrap within a frame.
- ready during a frame: goes high again as soon as hold is consumed (entry to START). At most one frame is in flight and one is queued.
- Simultaneous accept and consume: a valid && ready accept on the final STOP cycle with hold empty is not consumed that edge. The next frame enters START via IDLE, giving one IDLE cycle of tx=1.
- Frame length: (NUM_DATA_BITS+3)*OVERSAMPLING cycles, which is 176 at the defaults.

Optional Feature:
- UART_TX_TWO_STOP_EN defined: STOP_BIT lasts 2*OVERSAMPLING cycles; done fires after the second stop bit. Frame length becomes (NUM_DATA_BITS+4)*OVERSAMPLING.
- Undefined: a single stop bit of OVERSAMPLING cycles.

Decomposition:
- Shared header uart_globals.svh holds OVERSAMPLING, NUM_DATA_BITS, NUM_PARITY_BIT, PARITY_EVEN/PARITY_ODD, STATES_NUM, and the STATE_* codes.
- Add STATE_START_BIT to that header; the receiver ignores it.
- One natural sub-module: uart_parity_gen, a combinational word→parity-bit block honouring the parity macro. The receiver's checker can be reworked to reuse it later.

Test Plan:
- Reset mid-frame: assert reset during DATA_BITS → tx=1, busy=0, ready=0 at once. Deassert reset with enable=1 → ready=1, and no done pulse occurs.
- Single frame, 0x07 with PARITY_EVEN, OVERSAMPLING=16:
  - tx falls 1 cycle after accept.
  - Bit sequence 0,1,1,1,0,0,0,0,0,1(parity),1(stop), each bit 16 cycles.
  - done pulses at cycle 176; busy is high for cycles 1–176.
- Odd parity, 0x55 with PARITY_ODD → parity bit 1. Re-run with PARITY_EVEN → parity bit 0.
- Back-to-back: send 0xA5, then offer 0x3C while ready is high mid-frame. The second start bit begins the cycle after the first frame's final stop cycle, with no idle gap; done pulses twice, 176 cycles apart.
- Abort: drop enable during the parity bit → tx=1 next cycle, state IDLE, hold cleared, no done. Re-enable and send 0x81 → a clean full frame.
- Loopback: uart_tx.tx wired to uart_rx.rx on a shared baud clock, sending 0x00, 0xFF, 0x5A, 0xC3 → the receiver's data matches each word, its done pulses four times, and its error stays 0. Repeat with UART_TX_TWO_STOP_EN defined and expect the same result.
